soc_system_pio_status: RTL and testbench



---
 rtl/soc_system_pio_status.sv | 90 +++++++++
 tb/tb_soc_system_pio_status.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_system_pio_status.sv
// Avalon-MM input PIO returning FPGA status bits to the HPS: synchronized live
// value, per-bit edge capture (write-1-to-clear), interrupt mask and a saturating event counter.
module soc_system_pio_status #(
  parameter int WIDTH     = 32,
  parameter int EDGE_TYPE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam logic [15:0] EV_MAX = 16'hFFFF;

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] edge_vec;
  logic [WIDTH-1:0] cap_clr;
  logic [15:0]      ev_count;
  logic             wr_en;
  logic             any_edge;

  // Avalon-MM slave, no wait states: a write is accepted on any clock edge where
  // chipselect=1 and write_n=0; reads are combinational on address and have no side effects.
  assign wr_en = chipselect & ~write_n;

  always_comb begin
    edge_vec = '0;
    case (EDGE_TYPE)
      0:       edge_vec = s2 & ~prev;
      1:       edge_vec = ~s2 & prev;
      default: edge_vec = s2 ^ prev;
    endcase
  end

  assign any_edge = |edge_vec;
  assign cap_clr  = (wr_en && address == 2'd2) ? writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1   <= '0;
      s2   <= '0;
      prev <= '0;
    end else begin
      s1   <= in_port;
      s2   <= s1;
      prev <= s2;
    end
  end

  // Edge set is OR-ed after the clear so a same-cycle edge always survives the W1C.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_mask <= '0;
      edge_cap <= '0;
      ev_count <= '0;
    end else begin
      edge_cap <= (edge_cap & ~cap_clr) | edge_vec;
      if (wr_en && address == 2'd1) begin
        irq_mask <= writedata[WIDTH-1:0];
      end
      if (wr_en && address == 2'd3) begin
        ev_count <= any_edge ? 16'd1 : 16'd0;
      end else if (any_edge && ev_count != EV_MAX) begin
        ev_count <= ev_count + 16'd1;
      end
    end
  end

  assign irq = |(edge_cap & irq_mask);

  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata[WIDTH-1:0] = s2;
      2'd1:    readdata[WIDTH-1:0] = irq_mask;
      2'd2:    readdata[WIDTH-1:0] = edge_cap;
      default: readdata[15:0]      = ev_count;
    endcase
  end

endmodule

// File: tb/tb_soc_system_pio_status.sv
// Bench for soc_system_pio_status: a rising-edge 32-bit instance and an any-edge
// 8-bit instance share the bus and are checked against a cycle-level reference model.
module tb_soc_system_pio_status;

  logic        clk;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata_a;
  logic [31:0] readdata_b;
  logic [31:0] in_a;
  logic [7:0]  in_b;
  logic        irq_a;
  logic        irq_b;

  int n_checks;
  int n_fail;

  // reference model: per instance, the inputs sampled at the last four edges (index 0 newest)
  logic [31:0] smp[2][4];
  logic [31:0] m_mask[2];
  logic [31:0] m_cap[2];
  int          m_cnt[2];
  logic [31:0] wmask[2];
  int          etype[2];

  soc_system_pio_status u_dut_a (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata_a),
    .in_port(in_a), .irq(irq_a)
  );

  soc_system_pio_status #(.WIDTH(8), .EDGE_TYPE(2)) u_dut_b (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata_b),
    .in_port(in_b), .irq(irq_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  // scoreboard helpers
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 4; j++) smp[i][j] = '0;
      m_mask[i] = '0;
      m_cap[i]  = '0;
      m_cnt[i]  = 0;
    end
  endtask

  function automatic logic [31:0] exp_rd(input int i, input logic [1:0] a);
    case (a)
      2'd0:    return smp[i][1];
      2'd1:    return m_mask[i];
      2'd2:    return m_cap[i];
      default: return 32'(m_cnt[i]);
    endcase
  endfunction

  function automatic logic exp_irq(input int i);
    return |(m_cap[i] & m_mask[i]);
  endfunction

  // one clock edge: advance the model with exactly what the DUT sampled at that edge
  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        for (int j = 0; j < 4; j++) smp[i][j] = '0;
        m_mask[i] = '0;
        m_cap[i]  = '0;
        m_cnt[i]  = 0;
      end else begin
        logic [31:0] e;
        logic [31:0] clr;
        logic        w;
        w = chipselect && !write_n;
        for (int j = 3; j > 0; j--) smp[i][j] = smp[i][j-1];
        smp[i][0] = ((i == 0) ? in_a : {24'h0, in_b}) & wmask[i];
        // an input change seen two edges ago against the one seen three edges ago
        if (etype[i] == 0)      e = smp[i][2] & ~smp[i][3];
        else if (etype[i] == 1) e = ~smp[i][2] & smp[i][3];
        else                    e = smp[i][2] ^ smp[i][3];
        clr = (w && address == 2'd2) ? (writedata & wmask[i]) : '0;
        m_cap[i] = (m_cap[i] & ~clr) | e;
        if (w && address == 2'd1) m_mask[i] = writedata & wmask[i];
        if (w && address == 2'd3)  m_cnt[i] = (e != 0) ? 1 : 0;
        else if (e != 0 && m_cnt[i] < 65535) m_cnt[i]++;
      end
    end
    #1;
  endtask

  // driver tasks
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a);
    address = a;
    #1;
    chk($sformatf("%s_a_r%0d", tag, a), readdata_a, exp_rd(0, a));
    chk($sformatf("%s_b_r%0d", tag, a), readdata_b, exp_rd(1, a));
  endtask

  task automatic check_all(input string tag);
    for (int a = 0; a < 4; a++) rd_chk(tag, 2'(a));
    chk({tag, "_irq_a"}, {31'h0, irq_a}, {31'h0, exp_irq(0)});
    chk({tag, "_irq_b"}, {31'h0, irq_b}, {31'h0, exp_irq(1)});
  endtask

  // staggered activity: A gets a rising edge every cycle, B a toggle every cycle
  task automatic drive_pattern(input int c);
    in_a = '0;
    for (int j = 0; j < 4; j++) in_a[j] = ((c + j) % 4) < 2;
    in_b    = '0;
    in_b[0] = ((c / 2) % 2) == 1;
    in_b[1] = (((c + 1) / 2) % 2) == 1;
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    wmask[0]   = 32'hFFFF_FFFF;
    wmask[1]   = 32'h0000_00FF;
    etype[0]   = 0;
    etype[1]   = 2;
    reset      = 1'b1;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_a       = '0;
    in_b       = '0;
    model_reset();

    // reset and idle
    ticks(2);
    chk("rst_irq_a", {31'h0, irq_a}, 32'h0);
    chk("rst_irq_b", {31'h0, irq_b}, 32'h0);
    reset = 1'b0;
    ticks(3);
    address = 2'd0;
    #1;
    chk("idle_data_a", readdata_a, 32'h0);
    check_all("idle");

    // synchronizer and data latency: drive before edge N
    in_a = 32'h0000_00A5;
    in_b = 8'h5A;
    tick();
    rd_chk("lat_n", 2'd0);
    tick();
    address = 2'd0;
    #1;
    chk("lat_n1_data_a", readdata_a, 32'hA5);
    chk("lat_n1_cap_a", {31'h0, irq_a}, 32'h0);
    tick();
    address = 2'd2;
    #1;
    chk("lat_n2_cap_a", readdata_a, 32'hA5);
    chk("lat_n2_cap_b", readdata_b, 32'h5A);
    address = 2'd3;
    #1;
    chk("lat_n2_cnt_a", readdata_a, 32'h1);
    check_all("lat");

    // mask enables an already-set capture bit, then W1C removes it
    wr(2'd1, 32'h04);
    chk("mask_irq_a", {31'h0, irq_a}, 32'h1);
    chk("mask_irq_b", {31'h0, irq_b}, 32'h0);
    wr(2'd2, 32'h04);
    chk("w1c_irq_a", {31'h0, irq_a}, 32'h0);
    address = 2'd2;
    #1;
    chk("w1c_cap_a", readdata_a, 32'hA1);
    check_all("w1c");

    // W1C of bit 3 at the same edge that a rising edge on bit 3 is detected
    in_a = 32'h0000_00AD;
    ticks(2);
    wr(2'd2, 32'h08);
    address = 2'd2;
    #1;
    chk("setwin_cap_a", readdata_a, 32'hA9);
    check_all("setwin");

    // counter clear coinciding with an edge
    in_a = 32'h0000_00BD;
    ticks(2);
    wr(2'd3, 32'h0);
    address = 2'd3;
    #1;
    chk("clr_edge_cnt_a", readdata_a, 32'h1);
    chk("clr_edge_cnt_b", readdata_b, 32'h0);
    check_all("clr_edge");

    // randomized traffic, every level held at least two cycles
    for (int it = 0; it < 200; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        in_a = $urandom;
        in_b = 8'($urandom_range(0, 255));
      end
      if ($urandom_range(0, 2) != 0) wr(2'($urandom_range(0, 3)), $urandom);
      else                           tick();
      tick();
      check_all($sformatf("rnd%0d", it));
    end

    // counter saturation
    wr(2'd1, 32'h0);
    wr(2'd3, 32'h0);
    for (int c = 0; c < 65600; c++) begin
      drive_pattern(c);
      tick();
    end
    address = 2'd3;
    #1;
    chk("sat_cnt_a", readdata_a, 32'hFFFF);
    chk("sat_cnt_b", readdata_b, 32'hFFFF);
    check_all("sat");
    drive_pattern(65600);
    wr(2'd3, 32'h0);
    address = 2'd3;
    #1;
    chk("sat_clr_cnt_a", readdata_a, 32'h1);
    chk("sat_clr_cnt_b", readdata_b, 32'h1);
    check_all("sat_clr");

    // async reset mid-operation with EDGECAP = 0xFF and irq high
    in_a = '0;
    in_b = '0;
    ticks(4);
    wr(2'd2, 32'hFFFF_FFFF);
    wr(2'd1, 32'hFF);
    in_a = 32'hFF;
    in_b = 8'hFF;
    ticks(3);
    address = 2'd2;
    #1;
    chk("pre_rst_cap_a", readdata_a, 32'hFF);
    chk("pre_rst_cap_b", readdata_b, 32'hFF);
    chk("pre_rst_irq_a", {31'h0, irq_a}, 32'h1);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("async_irq_a", {31'h0, irq_a}, 32'h0);
    chk("async_irq_b", {31'h0, irq_b}, 32'h0);
    chk("async_cap_a", readdata_a, 32'h0);
    chk("async_cap_b", readdata_b, 32'h0);

    // release with in_port bit 0 already high
    in_a = 32'h1;
    in_b = 8'h1;
    ticks(2);
    reset = 1'b0;
    tick();
    rd_chk("rel_e1", 2'd2);
    tick();
    rd_chk("rel_e2", 2'd2);
    tick();
    address = 2'd2;
    #1;
    chk("rel_e3_cap_a", readdata_a, 32'h1);
    chk("rel_e3_cap_b", readdata_b, 32'h1);
    check_all("rel");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
